// File: rtl/cmd_rx_parser_pkg.sv
// Shared constants, response payload type and FSM encoding for the command parser.
package cmd_rx_parser_pkg;

    localparam logic [7:0] SOF_BYTE      = 8'hA5;
    localparam logic [7:0] ACK_BYTE      = 8'h5A;
    localparam logic [7:0] NAK_BYTE      = 8'hEE;

    localparam logic [7:0] CMD_SET_KEY   = 8'h01;
    localparam logic [7:0] CMD_SET_PT    = 8'h02;
    localparam logic [7:0] CMD_SET_DELAY = 8'h03;
    localparam logic [7:0] CMD_RUN       = 8'h04;

    localparam logic [7:0] ERR_CSUM      = 8'h01;
    localparam logic [7:0] ERR_BUSY      = 8'h02;
    localparam logic [7:0] ERR_FORMAT    = 8'h03;

    localparam int unsigned MAX_PAY_BYTES = 8;
    localparam int unsigned BUF_W         = 8 * MAX_PAY_BYTES;
    localparam logic [7:0]  DELAY_RST     = 8'd15;

    // Two-byte response: header (ACK/NAK) followed by command echo or error code
    typedef struct packed {
        logic [7:0] code;
        logic [7:0] arg;
    } resp_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_LEN,
        S_GET_PAY,
        S_GET_CSUM,
        S_EXEC,
        S_RESP0,
        S_WAIT0,
        S_RESP1,
        S_WAIT1
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_rx_parser_byte_timeout.sv
// Inter-byte silence counter: cleared by each received byte, flags expiry while enabled.
module cmd_rx_parser_byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);
    localparam int unsigned CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count idle cycles, holding at the expiry value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/cmd_rx_parser.sv
// UART command frame parser: collects SOF/CMD/LEN/payload/CSUM, commits registers, answers ACK/NAK.
module cmd_rx_parser
    import cmd_rx_parser_pkg::*;
#(
    parameter int unsigned N              = 16,
    parameter int unsigned M              = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             c10_resetn,
    input  logic             rx_dv,
    input  logic [7:0]       rx_byte,
    input  logic             run_busy,
    input  logic             tx_done,
    output logic             tx_dv,
    output logic [7:0]       tx_byte,
    output logic [N*M-1:0]   key_o,
    output logic [2*N-1:0]   pt_o,
    output logic [7:0]       delay_o,
    output logic             start_o,
    output logic [7:0]       err_cnt_o
);
    localparam int unsigned KEY_SIZE   = N * M;
    localparam int unsigned BLOCK_SIZE = 2 * N;
    localparam logic [7:0]  KEY_LEN    = 8'(KEY_SIZE / 8);
    localparam logic [7:0]  PT_LEN     = 8'(BLOCK_SIZE / 8);

    state_e                  state_q, state_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              csum_q, csum_d;
    logic [3:0]              pcnt_q, pcnt_d;
    logic [BUF_W-1:0]        buf_q, buf_d;
    resp_t                   resp_q, resp_d;
    logic [KEY_SIZE-1:0]     key_q, key_d;
    logic [BLOCK_SIZE-1:0]   pt_q, pt_d;
    logic [7:0]              delay_q, delay_d;
    logic                    start_q, start_d;
    logic                    tx_dv_q, tx_dv_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic                    in_get_c;
    logic                    expired_c;
    logic                    fmt_ok_c;
    logic [3:0]              pcnt_inc_c;

    assign in_get_c   = state_q inside {S_GET_CMD, S_GET_LEN, S_GET_PAY, S_GET_CSUM};
    assign pcnt_inc_c = pcnt_q + 4'd1;

    cmd_rx_parser_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (c10_resetn),
        .clr_i      (rx_dv),
        .en_i       (in_get_c),
        .expired_c_o(expired_c)
    );

    // Known command with the length it requires
    always_comb begin
        case (cmd_q)
            CMD_SET_KEY:   fmt_ok_c = (len_q == KEY_LEN);
            CMD_SET_PT:    fmt_ok_c = (len_q == PT_LEN);
            CMD_SET_DELAY: fmt_ok_c = (len_q == 8'd1);
            CMD_RUN:       fmt_ok_c = (len_q == 8'd0);
            default:       fmt_ok_c = 1'b0;
        endcase
    end

    // Next-state and output logic; the verdict is taken with the CSUM byte so that
    // register commits and start_o are visible during the EXEC cycle
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        csum_d    = csum_q;
        pcnt_d    = pcnt_q;
        buf_d     = buf_q;
        resp_d    = resp_q;
        key_d     = key_q;
        pt_d      = pt_q;
        delay_d   = delay_q;
        start_d   = 1'b0;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (rx_dv && rx_byte == SOF_BYTE) begin
                    state_d = S_GET_CMD;
                    csum_d  = '0;
                    pcnt_d  = '0;
                    buf_d   = '0;
                end
            end
            S_GET_CMD: begin
                if (rx_dv) begin
                    cmd_d   = rx_byte;
                    csum_d  = rx_byte;
                    state_d = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                if (rx_dv) begin
                    len_d  = rx_byte;
                    csum_d = csum_q ^ rx_byte;
                    if (rx_byte > 8'(MAX_PAY_BYTES)) begin
                        resp_d    = '{code: NAK_BYTE, arg: ERR_FORMAT};
                        err_cnt_d = sat_inc8(err_cnt_q);
                        tx_dv_d   = 1'b1;
                        tx_byte_d = NAK_BYTE;
                        state_d   = S_RESP0;
                    end else if (rx_byte == 8'd0) begin
                        state_d = S_GET_CSUM;
                    end else begin
                        state_d = S_GET_PAY;
                    end
                end
            end
            S_GET_PAY: begin
                if (rx_dv) begin
                    buf_d  = {buf_q[BUF_W-9:0], rx_byte};
                    csum_d = csum_q ^ rx_byte;
                    pcnt_d = pcnt_inc_c;
                    if ({4'd0, pcnt_inc_c} == len_q) begin
                        state_d = S_GET_CSUM;
                    end
                end
            end
            S_GET_CSUM: begin
                if (rx_dv) begin
                    state_d = S_EXEC;
                    if (csum_q != rx_byte) begin
                        resp_d    = '{code: NAK_BYTE, arg: ERR_CSUM};
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end else if (!fmt_ok_c) begin
                        resp_d    = '{code: NAK_BYTE, arg: ERR_FORMAT};
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end else if (cmd_q == CMD_RUN && run_busy) begin
                        resp_d    = '{code: NAK_BYTE, arg: ERR_BUSY};
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end else begin
                        resp_d = '{code: ACK_BYTE, arg: cmd_q};
                        case (cmd_q)
                            CMD_SET_KEY:   key_d   = KEY_SIZE'(buf_q);
                            CMD_SET_PT:    pt_d    = BLOCK_SIZE'(buf_q);
                            CMD_SET_DELAY: delay_d = buf_q[7:0];
                            default:       start_d = 1'b1;
                        endcase
                    end
                end
            end
            S_EXEC: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = resp_q.code;
                state_d   = S_RESP0;
            end
            S_RESP0: begin
                state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (tx_done) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = resp_q.arg;
                    state_d   = S_RESP1;
                end
            end
            S_RESP1: begin
                state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Silence inside a frame drops it without a response; a byte in the same cycle wins
        if (expired_c && !rx_dv) begin
            state_d   = S_IDLE;
            err_cnt_d = sat_inc8(err_cnt_q);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge c10_resetn) begin
        if (!c10_resetn) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            len_q     <= '0;
            csum_q    <= '0;
            pcnt_q    <= '0;
            buf_q     <= '0;
            resp_q    <= '0;
            key_q     <= '0;
            pt_q      <= '0;
            delay_q   <= DELAY_RST;
            start_q   <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            csum_q    <= csum_d;
            pcnt_q    <= pcnt_d;
            buf_q     <= buf_d;
            resp_q    <= resp_d;
            key_q     <= key_d;
            pt_q      <= pt_d;
            delay_q   <= delay_d;
            start_q   <= start_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tx_dv     = tx_dv_q;
    assign tx_byte   = tx_byte_q;
    assign key_o     = key_q;
    assign pt_o      = pt_q;
    assign delay_o   = delay_q;
    assign start_o   = start_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_cmd_rx_parser.sv
// Randomised frame-level bench for cmd_rx_parser with a behavioural response/register model.
module tb_cmd_rx_parser;

    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        c10_resetn;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        run_busy;
    logic        tx_done;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [63:0] key_o;
    logic [31:0] pt_o;
    logic [7:0]  delay_o;
    logic        start_o;
    logic [7:0]  err_cnt_o;

    always #5 clk = ~clk;

    cmd_rx_parser #(.N(16), .M(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .c10_resetn(c10_resetn),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .run_busy  (run_busy),
        .tx_done   (tx_done),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .key_o     (key_o),
        .pt_o      (pt_o),
        .delay_o   (delay_o),
        .start_o   (start_o),
        .err_cnt_o (err_cnt_o)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned last_cyc;
    logic [7:0]  tx_q[$];
    int unsigned txc_q[$];
    int unsigned st_q[$];
    logic        uart_hold = 1'b0;
    logic        uart_busy = 1'b0;
    logic [7:0]  fr_pay[8];

    // reference model state
    logic [63:0] m_key;
    logic [31:0] m_pt;
    logic [7:0]  m_delay;
    logic [7:0]  m_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    always @(negedge clk) begin
        if (tx_dv === 1'b1) begin
            tx_q.push_back(tx_byte);
            txc_q.push_back(cyc);
        end
        if (start_o === 1'b1) st_q.push_back(cyc);
    end

    // UART transmitter stand-in: acknowledges each byte after a random delay
    initial begin
        logic [7:0] held;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            while (tx_dv === 1'b1 && !uart_hold) begin
                uart_busy = 1'b1;
                held = tx_byte;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                check_eq("tx_hold", 64'(tx_byte), 64'(held));
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                uart_busy = 1'b0;
            end
        end
    end

    function automatic int exp_len(input logic [7:0] c);
        case (c)
            8'h01:   return 8;
            8'h02:   return 4;
            8'h03:   return 1;
            8'h04:   return 0;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'd255) ? v : v + 8'd1;
    endfunction

    function automatic int pick_gap(input int fixed_gap);
        return (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 3));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        last_cyc = cyc;
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ":key"},   key_o,            m_key);
        check_eq({tag, ":pt"},    64'(pt_o),        64'(m_pt));
        check_eq({tag, ":delay"}, 64'(delay_o),     64'(m_delay));
        check_eq({tag, ":err"},   64'(err_cnt_o),   64'(m_err));
    endtask

    task automatic clear_mon();
        tx_q.delete();
        txc_q.delete();
        st_q.delete();
    endtask

    // Full frame (or LEN>8 prefix) and check of the two-byte answer, start pulse and registers
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                             input bit bad_csum, input int fixed_gap);
        logic [7:0]  sum, csum, eb0, eb1, gb;
        logic [63:0] acc;
        bit          est;
        int          t;
        sum = cmd ^ len;
        if (len <= 8'd8) for (int i = 0; i < int'(len); i++) sum ^= fr_pay[i];
        csum = bad_csum ? (sum ^ 8'($urandom_range(1, 255))) : sum;
        est = 1'b0;
        if (len > 8'd8) begin
            eb0 = 8'hEE; eb1 = 8'h03;
        end else if (bad_csum) begin
            eb0 = 8'hEE; eb1 = 8'h01;
        end else if (exp_len(cmd) != int'(len)) begin
            eb0 = 8'hEE; eb1 = 8'h03;
        end else if (cmd == 8'h04 && run_busy) begin
            eb0 = 8'hEE; eb1 = 8'h02;
        end else begin
            eb0 = 8'h5A; eb1 = cmd;
            acc = '0;
            for (int i = 0; i < int'(len); i++) acc = (acc << 8) | 64'(fr_pay[i]);
            case (cmd)
                8'h01:   m_key = acc;
                8'h02:   m_pt = 32'(acc);
                8'h03:   m_delay = 8'(acc);
                default: est = 1'b1;
            endcase
        end
        if (eb0 == 8'hEE) m_err = sat(m_err);

        clear_mon();
        repeat ($urandom_range(0, 2)) begin
            do gb = 8'($urandom); while (gb == 8'hA5);
            send_byte(gb, pick_gap(fixed_gap));
        end
        send_byte(8'hA5, pick_gap(fixed_gap));
        send_byte(cmd, pick_gap(fixed_gap));
        if (len > 8'd8) begin
            send_byte(len, 0);
        end else begin
            send_byte(len, pick_gap(fixed_gap));
            for (int i = 0; i < int'(len); i++) send_byte(fr_pay[i], pick_gap(fixed_gap));
            send_byte(csum, 0);
        end

        t = 0;
        while ((tx_q.size() < 2 || uart_busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);

        check_eq({tag, ":ntx"}, 64'(tx_q.size()), 64'd2);
        if (tx_q.size() == 2) begin
            check_eq({tag, ":tx0"}, 64'(tx_q[0]), 64'(eb0));
            check_eq({tag, ":tx1"}, 64'(tx_q[1]), 64'(eb1));
            check_eq({tag, ":tx_lat"}, 64'(txc_q[0]),
                     64'((len > 8'd8) ? last_cyc : last_cyc + 1));
        end
        check_eq({tag, ":nstart"}, 64'(st_q.size()), 64'(est));
        if (est && st_q.size() == 1) check_eq({tag, ":start_lat"}, 64'(st_q[0]), 64'(last_cyc));
        check_regs(tag);
    endtask

    // Partial frame followed by silence: silent abort, error counted, nothing committed
    task automatic run_trunc(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                             input int nbytes);
        logic [7:0] fr[$];
        fr = {8'hA5, cmd, len};
        for (int i = 0; i < int'(len); i++) fr.push_back(fr_pay[i]);
        m_err = sat(m_err);
        clear_mon();
        for (int i = 0; i < nbytes; i++) send_byte(fr[i], pick_gap(-1));
        repeat (TO + 10) @(negedge clk);
        check_eq({tag, ":ntx"},    64'(tx_q.size()), 64'd0);
        check_eq({tag, ":nstart"}, 64'(st_q.size()), 64'd0);
        check_regs(tag);
    endtask

    initial begin
        int          kind, t;
        logic [7:0]  c, l;

        c10_resetn = 1'b0;
        rx_dv      = 1'b0;
        rx_byte    = 8'h00;
        run_busy   = 1'b0;
        m_key = '0; m_pt = '0; m_delay = 8'd15; m_err = '0;
        repeat (3) @(negedge clk);
        c10_resetn = 1'b1;
        @(negedge clk);
        check_regs("reset");
        check_eq("reset:tx_dv",   64'(tx_dv),   64'd0);
        check_eq("reset:tx_byte", 64'(tx_byte), 64'd0);
        check_eq("reset:start",   64'(start_o), 64'd0);

        // key load example
        fr_pay = '{8'h19, 8'h18, 8'h11, 8'h10, 8'h09, 8'h08, 8'h01, 8'h00};
        run_frame("set_key", 8'h01, 8'h08, 1'b0, -1);
        check_eq("set_key:value", key_o, 64'h1918111009080100);

        // plaintext with corrupted checksum
        fr_pay = '{8'h65, 8'h65, 8'h68, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("pt_badcs", 8'h02, 8'h04, 1'b1, -1);
        check_eq("pt_badcs:errcnt", 64'(err_cnt_o), 64'd1);

        // RUN idle and busy
        run_busy = 1'b0;
        run_frame("run_idle", 8'h04, 8'h00, 1'b0, -1);
        run_busy = 1'b1;
        run_frame("run_busy", 8'h04, 8'h00, 1'b0, -1);
        run_busy = 1'b0;

        // timeout after A5 03, then a good delay frame
        fr_pay[0] = 8'h03;
        run_trunc("timeout", 8'h03, 8'h01, 2);
        fr_pay[0] = 8'h2A;
        run_frame("delay", 8'h03, 8'h01, 1'b0, -1);
        check_eq("delay:value", 64'(delay_o), 64'h2A);

        // slow sender just inside the timeout window
        for (int i = 0; i < 8; i++) fr_pay[i] = 8'($urandom);
        run_frame("slow_pt", 8'h02, 8'h04, 1'b0, int'(TO) - 2);

        // oversized LEN answered at once
        run_frame("len9", 8'h09, 8'h09, 1'b0, -1);

        // reset while waiting on the first response byte
        uart_hold = 1'b1;
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h09, 0);
        send_byte(8'h09, 0);
        t = 0;
        while (tx_q.size() < 1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("rst_mid:tx0", 64'(tx_q.size()), 64'd1);
        @(negedge clk);
        c10_resetn = 1'b0;
        #1;
        m_key = '0; m_pt = '0; m_delay = 8'd15; m_err = '0;
        check_eq("rst_mid:tx_dv", 64'(tx_dv), 64'd0);
        check_regs("rst_mid");
        @(negedge clk);
        c10_resetn = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        check_eq("rst_mid:no_tx",    64'(tx_q.size()), 64'd0);
        check_eq("rst_mid:no_start", 64'(st_q.size()), 64'd0);
        uart_hold = 1'b0;

        // randomised frames of every class
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 6));
            for (int i = 0; i < 8; i++) fr_pay[i] = 8'($urandom);
            run_busy = 1'($urandom_range(0, 1));
            case (kind)
                0: begin
                    c = 8'($urandom_range(1, 3));
                    run_frame("rnd_ok", c, 8'(exp_len(c)), 1'b0, -1);
                end
                1: run_frame("rnd_run", 8'h04, 8'h00, 1'b0, -1);
                2: begin
                    c = 8'($urandom_range(1, 4));
                    run_frame("rnd_badcs", c, 8'(exp_len(c)), 1'b1, -1);
                end
                3: begin
                    do c = 8'($urandom); while (exp_len(c) >= 0);
                    run_frame("rnd_unk", c, 8'($urandom_range(0, 8)), 1'b0, -1);
                end
                4: begin
                    c = 8'($urandom_range(1, 4));
                    do l = 8'($urandom_range(0, 8)); while (int'(l) == exp_len(c));
                    run_frame("rnd_badlen", c, l, 1'b0, -1);
                end
                5: run_frame("rnd_biglen", 8'($urandom), 8'($urandom_range(9, 255)), 1'b0, -1);
                default: begin
                    c = 8'($urandom_range(1, 4));
                    l = 8'(exp_len(c));
                    run_trunc("rnd_trunc", c, l, int'($urandom_range(1, 3 + int'(l))));
                end
            endcase
        end
        run_busy = 1'b0;

        // error counter saturation
        for (int f = 0; f < 260; f++) begin
            run_frame("sat", 8'($urandom), 8'($urandom_range(9, 255)), 1'b0, 0);
        end
        check_eq("sat:final", 64'(err_cnt_o), 64'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmd_rx_parser.md
CMD_RX_PARSER -- requirements
Module: cmd_rx_parser

Interface
REQ-001 SHALL have parameter N, default 16, cipher word size in bits.
REQ-002 SHALL have parameter M, default 4, key words; KEY_SIZE=N*M, BLOCK_SIZE=2*N.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port c10_resetn  input  1  asynchronous reset, active-low.
REQ-006 SHALL have port rx_dv  input  1  one-cycle strobe, rx_byte valid.
REQ-007 SHALL have port rx_byte  input  8  received UART byte.
REQ-008 SHALL have port run_busy  input  1  capture/encryption in progress.
REQ-009 SHALL have port tx_done  input  1  one-cycle strobe, UART transmitter finished the byte.
REQ-010 SHALL have port tx_dv  output  1  one-cycle request to send tx_byte.
REQ-011 SHALL have port tx_byte  output  8  response byte.
REQ-012 SHALL have port key_o  output  KEY_SIZE  committed cipher key.
REQ-013 SHALL have port pt_o  output  BLOCK_SIZE  committed plaintext.
REQ-014 SHALL have port delay_o  output  8  committed sensor delay/calibration byte.
REQ-015 SHALL have port start_o  output  1  one-cycle run pulse.
REQ-016 SHALL have port err_cnt_o  output  8  saturating count of rejected or aborted frames.

Function
REQ-017 Frame SHALL be: SOF 0xA5, CMD, LEN, LEN payload bytes, CSUM; CSUM = XOR of CMD, LEN and all payload bytes.
REQ-018 Commands SHALL be: 0x01 SET_KEY (LEN=KEY_SIZE/8), 0x02 SET_PT (LEN=BLOCK_SIZE/8), 0x03 SET_DELAY (LEN=1), 0x04 RUN (LEN=0).
REQ-019 Payload SHALL be big-endian: first payload byte -> MSB of the target register.
REQ-020 States SHALL be IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CSUM, EXEC, RESP0, WAIT0, RESP1, WAIT1.
REQ-021 IDLE: rx_dv with byte 0xA5 -> GET_CMD; any other byte is discarded silently.
REQ-022 GET_LEN: LEN>8 -> RESP0 with NAK code 0x03, no payload consumed; LEN=0 -> GET_CSUM; else -> GET_PAY.
REQ-023 GET_PAY SHALL shift bytes into an 8-byte buffer and count them; -> GET_CSUM after LEN bytes.
REQ-024 EXEC (one cycle after CSUM byte) SHALL evaluate in priority: checksum mismatch -> NAK 0x01; unknown CMD or LEN mismatch -> NAK 0x03; RUN with run_busy=1 -> NAK 0x02; else ACK.
REQ-025 On ACK, EXEC SHALL update only the addressed register; RUN SHALL assert start_o for exactly that one cycle.
REQ-026 Registers SHALL NOT change on NAK, timeout or partial frame.
REQ-027 Response SHALL be two bytes: ACK = 0x5A then CMD; NAK = 0xEE then error code.
REQ-028 RESPx SHALL pulse tx_dv one cycle with tx_byte stable; WAITx SHALL hold tx_byte until tx_done; WAIT1 -> IDLE.
REQ-029 rx_dv in EXEC/RESP/WAIT states SHALL be ignored.
REQ-030 Timeout counter SHALL clear on every rx_dv; in GET_* states reaching TIMEOUT_CYCLES-1 SHALL abort to IDLE, no response.
REQ-031 err_cnt_o SHALL increment once per NAK or timeout, saturating at 255.
REQ-032 Latency: start_o SHALL assert exactly 1 cycle after rx_dv of the CSUM byte; tx_dv 1 cycle after that.

Reset
REQ-033 c10_resetn low SHALL asynchronously force: state IDLE, key_o 0, pt_o 0, delay_o 15, start_o 0, tx_dv 0, tx_byte 0, err_cnt_o 0, counters and buffer 0.
REQ-034 Reset mid-frame or mid-response SHALL discard the frame; no tx_dv or start_o after release until a new frame completes.

Structure
REQ-035 Shared package SHALL hold SOF, ACK/NAK bytes, command codes, error codes, state encoding.
REQ-036 One sub-module, byte_timeout (counter with clear and expiry flag), is natural; the rest is a single FSM module.

Verification
REQ-037 A5 01 08 19 18 11 10 09 08 01 00 CSUM -> key_o=0x1918111009080100, tx 5A 01.
REQ-038 A5 02 04 65 65 68 77 with wrong CSUM -> pt_o unchanged, tx EE 01, err_cnt_o=1.
REQ-039 A5 04 00 04 with run_busy=0 -> start_o one pulse, tx 5A 04; same with run_busy=1 -> no pulse, tx EE 02.
REQ-040 A5 03 then silence TIMEOUT_CYCLES -> IDLE, no tx, err_cnt_o+1; next A5 03 01 2A 28 -> delay_o=0x2A.
REQ-041 A5 09 09 -> immediate EE 03; c10_resetn low during WAIT0 -> tx_dv 0, delay_o=15.
